tdp_bram_be: RTL and testbench

True dual-port block RAM with per-port byte-lane write enables, configurable read latency and write mode, per-port read-valid tracking, and address-collision detection. It is the general-purpose on-chip buffer for RoCE stack wrapper logic such as QP context tables, WQE staging and per-flow state. Both ports share one clock. An optional build-time init sequencer zeroes the array after reset.

---
 rtl/tdp_bram_be.sv | 174 +++++++++++++++++
 tb/tb_tdp_bram_be.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/tdp_bram_be.sv
// True dual-port byte-enabled block RAM with collision detection and read-valid pipelines.
// Optional TDP_BRAM_INIT_ZERO_EN macro adds a post-reset sequencer that zeroes the array.

module tdp_bram_be_rdpipe #(
  parameter int DW = 32,
  parameter int RL = 1
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          i_acc,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_dout,
  output logic          o_vld
);
  logic          r_vld1;
  logic [DW-1:0] r_d1;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_vld1 <= 1'b0;
      r_d1   <= '0;
    end else begin
      r_vld1 <= i_acc;
      if (i_acc) r_d1 <= i_din;
    end
  end

  generate
    if (RL == 2) begin : g_s2
      logic          r_vld2;
      logic [DW-1:0] r_d2;
      always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
          r_vld2 <= 1'b0;
          r_d2   <= '0;
        end else begin
          r_vld2 <= r_vld1;
          if (r_vld1) r_d2 <= r_d1;
        end
      end
      assign o_dout = r_d2;
      assign o_vld  = r_vld2;
    end else begin : g_s1
      assign o_dout = r_d1;
      assign o_vld  = r_vld1;
    end
  endgenerate
endmodule

module tdp_bram_be #(
  parameter int DATA_WIDTH   = 32,
  parameter int BYTE_WIDTH   = 8,
  parameter int BRAM_DEPTH   = 256,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_MODE   = 0
) (
  input  logic                               clk_i,
  input  logic                               rstn_i,
  input  logic                               ena_i,
  input  logic                               enb_i,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   wea_i,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   web_i,
  input  logic [ADDR_WIDTH-1:0]              addra_i,
  input  logic [ADDR_WIDTH-1:0]              addrb_i,
  input  logic [DATA_WIDTH-1:0]              dia_i,
  input  logic [DATA_WIDTH-1:0]              dib_i,
  output logic [DATA_WIDTH-1:0]              douta_o,
  output logic [DATA_WIDTH-1:0]              doutb_o,
  output logic                               rvalida_o,
  output logic                               rvalidb_o,
  output logic                               collision_o,
  output logic [15:0]                        collision_cnt_o,
  output logic                               init_done_o
);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  localparam int IW = (BRAM_DEPTH > 1) ? $clog2(BRAM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(BRAM_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [BRAM_DEPTH];
  logic                  w_init_done;

`ifdef TDP_BRAM_INIT_ZERO_EN
  typedef enum logic {S_INIT, S_DONE} state_t;
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_init_addr;
  logic                  r_init_done;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= S_INIT;
      r_init_addr <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_init_addr <= r_init_addr + 1'b1;
          if (r_init_addr == ADDR_WIDTH'(BRAM_DEPTH-1)) r_state <= S_DONE;
        end
        default: r_init_done <= 1'b1;
      endcase
    end
  end
  assign w_init_done = r_init_done;
`else
  assign w_init_done = 1'b1;
`endif

  logic                  w_acca, w_accb, w_inra, w_inrb, w_wra, w_wrb, w_same, w_coll;
  logic [IW-1:0]         w_ia, w_ib;
  logic [DATA_WIDTH-1:0] w_mska, w_mskb, w_prea, w_preb, w_mrga, w_mrgb, w_wdb, w_rda, w_rdb;

  assign w_acca = ena_i & w_init_done;
  assign w_accb = enb_i & w_init_done;
  assign w_inra = {1'b0, addra_i} < DEPTH_L;
  assign w_inrb = {1'b0, addrb_i} < DEPTH_L;
  assign w_ia   = addra_i[IW-1:0];
  assign w_ib   = addrb_i[IW-1:0];
  assign w_wra  = w_acca & (|wea_i) & w_inra;
  assign w_wrb  = w_accb & (|web_i) & w_inrb;
  assign w_coll = w_acca & w_accb & (addra_i == addrb_i) & ((|wea_i) | (|web_i));
  assign w_same = w_wra & w_wrb & (addra_i == addrb_i);

  always_comb begin
    w_mska = '0;
    w_mskb = '0;
    for (int k = 0; k < NB; k++) begin
      w_mska[k*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{wea_i[k]}};
      w_mskb[k*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{web_i[k]}};
    end
  end

  assign w_prea = w_inra ? r_mem[w_ia] : '0;
  assign w_preb = w_inrb ? r_mem[w_ib] : '0;
  assign w_mrga = (w_prea & ~w_mska) | (dia_i & w_mska);
  assign w_mrgb = (w_preb & ~w_mskb) | (dib_i & w_mskb);
  // Same-address double write: B's lanes are layered over A's merge so both ports' disjoint lanes land.
  assign w_wdb  = ((w_same ? w_mrga : w_preb) & ~w_mskb) | (dib_i & w_mskb);

  assign w_rda = !w_inra ? '0 : (WRITE_MODE == 1 && !w_coll) ? w_mrga : w_prea;
  assign w_rdb = !w_inrb ? '0 : (WRITE_MODE == 1 && !w_coll) ? w_mrgb : w_preb;

  always_ff @(posedge clk_i) begin
`ifdef TDP_BRAM_INIT_ZERO_EN
    if (r_state == S_INIT) r_mem[r_init_addr[IW-1:0]] <= '0;
`endif
    if (w_wra && !w_same) r_mem[w_ia] <= w_mrga;
    if (w_wrb)            r_mem[w_ib] <= w_wdb;
  end

  logic        r_coll;
  logic [15:0] r_coll_cnt;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_coll     <= 1'b0;
      r_coll_cnt <= '0;
    end else begin
      r_coll <= w_coll;
      if (w_coll && r_coll_cnt != 16'hFFFF) r_coll_cnt <= r_coll_cnt + 16'd1;
    end
  end

  tdp_bram_be_rdpipe #(.DW(DATA_WIDTH), .RL(READ_LATENCY)) u_pipe_a (
    .clk_i(clk_i), .rstn_i(rstn_i), .i_acc(w_acca), .i_din(w_rda), .o_dout(douta_o), .o_vld(rvalida_o)
  );
  tdp_bram_be_rdpipe #(.DW(DATA_WIDTH), .RL(READ_LATENCY)) u_pipe_b (
    .clk_i(clk_i), .rstn_i(rstn_i), .i_acc(w_accb), .i_din(w_rdb), .o_dout(doutb_o), .o_vld(rvalidb_o)
  );

  assign collision_o     = r_coll;
  assign collision_cnt_o = r_coll_cnt;
  assign init_done_o     = w_init_done;
endmodule

// File: tb/tb_tdp_bram_be.sv
// Bench for tdp_bram_be: dut0 is read-first/latency 1/depth 256, dut1 is write-first/latency 2/depth 16.
module tb_tdp_bram_be;
  logic        clk = 1'b0, rstn = 1'b0;
  logic        ena = 1'b0, enb = 1'b0;
  logic [3:0]  wea = '0, web = '0;
  logic [7:0]  addra = '0, addrb = '0;
  logic [31:0] dia = '0, dib = '0;
  logic [31:0] da0, db0, da1, db1;
  logic        va0, vb0, va1, vb1, c0, c1, id0, id1;
  logic [15:0] cn0, cn1;
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  tdp_bram_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .BRAM_DEPTH(256), .ADDR_WIDTH(8),
                .READ_LATENCY(1), .WRITE_MODE(0)) dut0 (
    .clk_i(clk), .rstn_i(rstn), .ena_i(ena), .enb_i(enb), .wea_i(wea), .web_i(web),
    .addra_i(addra), .addrb_i(addrb), .dia_i(dia), .dib_i(dib), .douta_o(da0), .doutb_o(db0),
    .rvalida_o(va0), .rvalidb_o(vb0), .collision_o(c0), .collision_cnt_o(cn0), .init_done_o(id0));

  tdp_bram_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .BRAM_DEPTH(16), .ADDR_WIDTH(8),
                .READ_LATENCY(2), .WRITE_MODE(1)) dut1 (
    .clk_i(clk), .rstn_i(rstn), .ena_i(ena), .enb_i(enb), .wea_i(wea), .web_i(web),
    .addra_i(addra), .addrb_i(addrb), .dia_i(dia), .dib_i(dib), .douta_o(da1), .doutb_o(db1),
    .rvalida_o(va1), .rvalidb_o(vb1), .collision_o(c1), .collision_cnt_o(cn1), .init_done_o(id1));

  typedef struct {
    logic ena; logic [3:0] wea; logic [7:0] addra; logic [31:0] dia;
    logic enb; logic [3:0] web; logic [7:0] addrb; logic [31:0] dib;
    logic chk; logic [31:0] e0a, e0b, e1a, e1b; logic coll;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ea, input logic [3:0] wa, input logic [7:0] aa, input logic [31:0] xa,
                       input logic eb, input logic [3:0] wb, input logic [7:0] ab, input logic [31:0] xb);
    ena = ea; wea = wa; addra = aa; dia = xa;
    enb = eb; web = wb; addrb = ab; dib = xb;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 8'h0, 32'h0, 1'b0, 4'h0, 8'h0, 32'h0);
  endtask

  logic [31:0] h0a, h0b, h1a, h1b;
  int          cyc;
  logic        rv_seen;

  initial begin
    vecs[0]  = '{1'b1,4'hF,8'd5,32'hDEADBEEF, 1'b1,4'hF,8'd3,32'h11223344, 1'b0, 32'h0,32'h0,32'h0,32'h0, 1'b0};
    vecs[1]  = '{1'b1,4'h0,8'd3,32'h0, 1'b1,4'h0,8'd5,32'h0, 1'b1, 32'h11223344,32'hDEADBEEF,32'h11223344,32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1,4'h5,8'd3,32'hAABBCCDD, 1'b0,4'h0,8'd0,32'h0, 1'b1, 32'h11223344,32'h0,32'h11BB33DD,32'h0, 1'b0};
    vecs[3]  = '{1'b1,4'h0,8'd3,32'h0, 1'b0,4'h0,8'd0,32'h0, 1'b1, 32'h11BB33DD,32'h0,32'h11BB33DD,32'h0, 1'b0};
    vecs[4]  = '{1'b1,4'hF,8'd7,32'h0, 1'b1,4'hF,8'd9,32'h5, 1'b0, 32'h0,32'h0,32'h0,32'h0, 1'b0};
    vecs[5]  = '{1'b1,4'h3,8'd7,32'h000000FF, 1'b1,4'h6,8'd7,32'hFFFF0000, 1'b1, 32'h0,32'h0,32'h0,32'h0, 1'b1};
    vecs[6]  = '{1'b1,4'h0,8'd7,32'h0, 1'b1,4'h0,8'd7,32'h0, 1'b1, 32'h00FF00FF,32'h00FF00FF,32'h00FF00FF,32'h00FF00FF, 1'b0};
    vecs[7]  = '{1'b1,4'h0,8'd9,32'h0, 1'b1,4'hF,8'd9,32'h7, 1'b1, 32'h5,32'h5,32'h5,32'h5, 1'b1};
    vecs[8]  = '{1'b1,4'h0,8'd9,32'h0, 1'b1,4'h0,8'd9,32'h0, 1'b1, 32'h7,32'h7,32'h7,32'h7, 1'b0};
    vecs[9]  = '{1'b1,4'hF,8'd21,32'h12345678, 1'b0,4'h0,8'd0,32'h0, 1'b0, 32'h0,32'h0,32'h0,32'h0, 1'b0};
    vecs[10] = '{1'b1,4'h0,8'd21,32'h0, 1'b1,4'h0,8'd5,32'h0, 1'b1, 32'h12345678,32'hDEADBEEF,32'h0,32'hDEADBEEF, 1'b0};
    vecs[11] = '{1'b0,4'h0,8'd0,32'h0, 1'b0,4'h0,8'd0,32'h0, 1'b1, 32'h0,32'h0,32'h0,32'h0, 1'b0};
    vecs[12] = '{1'b1,4'h0,8'd9,32'hFFFFFFFF, 1'b1,4'h0,8'd9,32'h0, 1'b1, 32'h7,32'h7,32'h7,32'h7, 1'b0};
    vecs[13] = '{1'b1,4'h0,8'd9,32'h0, 1'b0,4'h0,8'd0,32'h0, 1'b1, 32'h7,32'h0,32'h7,32'h0, 1'b0};
    h0a = '0; h0b = '0; h1a = '0; h1b = '0;

    repeat (2) @(negedge clk);
    chk("rst douta0", da0, 32'h0);   chk("rst doutb1", db1, 32'h0);
    chk("rst rvalid", {va0, vb0, va1, vb1}, 32'h0);
    chk("rst coll", {c0, c1}, 32'h0); chk("rst cnt0", cn0, 16'h0);
`ifdef TDP_BRAM_INIT_ZERO_EN
    chk("rst init_done", {id0, id1}, 32'h0);
    rstn = 1'b1;
    cyc = 0; rv_seen = 1'b0;
    while (!id1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      rv_seen = rv_seen | va0 | vb0 | va1 | vb1;
      if (cyc == 4) drive(1'b1, 4'hF, 8'd2, 32'h0000ABCD, 1'b0, 4'h0, 8'd0, 32'h0);
      else idle();
    end
    chk("init1 cycles", cyc, 32'd17);
    while (!id0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      rv_seen = rv_seen | va0 | vb0 | va1 | vb1;
    end
    chk("init0 cycles", cyc, 32'd257);
    chk("init no rvalid", rv_seen, 1'b0);
    for (int a = 0; a < 16; a++) begin
      drive(1'b1, 4'h0, 8'(a), 32'h0, 1'b0, 4'h0, 8'd0, 32'h0);
      @(negedge clk); idle();
      @(negedge clk);
      chk($sformatf("init zero a%0d", a), da1, 32'h0);
    end
    rstn = 1'b0; @(negedge clk); rstn = 1'b1;
    repeat (8) @(negedge clk);
    rstn = 1'b0; @(negedge clk); rstn = 1'b1;
    cyc = 0;
    while (!id1 && cyc < 40) begin @(negedge clk); cyc++; end
    chk("init restart cycles", cyc, 32'd17);
    cyc = 0;
    while (!id0 && cyc < 400) begin @(negedge clk); cyc++; end
    chk("init0 done", id0, 1'b1);
`else
    chk("rst init_done", {id0, id1}, 32'h3);
    rstn = 1'b1;
`endif
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].ena, vecs[i].wea, vecs[i].addra, vecs[i].dia,
            vecs[i].enb, vecs[i].web, vecs[i].addrb, vecs[i].dib);
      @(negedge clk);
      if (vecs[i].ena) begin h0a = vecs[i].e0a; h1a = vecs[i].e1a; end
      if (vecs[i].enb) begin h0b = vecs[i].e0b; h1b = vecs[i].e1b; end
      chk($sformatf("v%0d rv0", i), {va0, vb0}, {30'h0, vecs[i].ena, vecs[i].enb});
      chk($sformatf("v%0d rv1 early", i), {va1, vb1}, 32'h0);
      chk($sformatf("v%0d coll", i), {c0, c1}, {30'h0, vecs[i].coll, vecs[i].coll});
      if (vecs[i].chk) begin
        chk($sformatf("v%0d d0a", i), da0, h0a);
        chk($sformatf("v%0d d0b", i), db0, h0b);
      end
      idle();
      @(negedge clk);
      chk($sformatf("v%0d rv1", i), {va1, vb1}, {30'h0, vecs[i].ena, vecs[i].enb});
      chk($sformatf("v%0d rv0 late", i), {va0, vb0}, 32'h0);
      chk($sformatf("v%0d coll off", i), {c0, c1}, 32'h0);
      if (vecs[i].chk) begin
        chk($sformatf("v%0d d1a", i), da1, h1a);
        chk($sformatf("v%0d d1b", i), db1, h1b);
      end
    end
    chk("cnt0 after table", cn0, 16'd2);
    chk("cnt1 after table", cn1, 16'd2);

    force dut0.r_coll_cnt = 16'hFFFE;
    force dut1.r_coll_cnt = 16'hFFFE;
    @(negedge clk);
    release dut0.r_coll_cnt;
    release dut1.r_coll_cnt;
    chk("cnt forced", cn0, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'hF, 8'd10, 32'h11111111, 1'b1, 4'hF, 8'd10, 32'h22222222);
      @(negedge clk);
      chk($sformatf("sat%0d coll", i), {c0, c1}, 32'h3);
      chk($sformatf("sat%0d cnt0", i), cn0, 16'hFFFF);
      chk($sformatf("sat%0d cnt1", i), cn1, 16'hFFFF);
    end
    idle();
    @(negedge clk);
    chk("sat coll off", {c0, c1}, 32'h0);
    drive(1'b1, 4'h0, 8'd10, 32'h0, 1'b0, 4'h0, 8'd0, 32'h0);
    @(negedge clk);
    chk("ww B wins d0", da0, 32'h22222222);
    idle();
    @(negedge clk);
    chk("ww B wins d1", da1, 32'h22222222);

    drive(1'b1, 4'h0, 8'd3, 32'h0, 1'b1, 4'h0, 8'd5, 32'h0);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("midrst rvalid", {va0, vb0, va1, vb1}, 32'h0);
    chk("midrst dout", {da0 | db0 | da1 | db1}, 32'h0);
    chk("midrst cnt", {cn0, cn1}, 32'h0);
    idle();
    @(negedge clk);
    rstn = 1'b1;
    rv_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      rv_seen = rv_seen | va0 | vb0 | va1 | vb1;
    end
    chk("midrst no late rvalid", rv_seen, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
